// File: rtl/serial_adder_if.sv
// Operand/result bundle between a controlling FSM (master) and the serial adder (slave).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract, DIGIT bits per clock through a registered carry.
// start->done takes WIDTH/DIGIT+1 edges; start is only honoured in IDLE (no queueing).
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_next;
  logic             ovf_next;

  assign dsum     = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
  // New digit enters at the MSB end so the full result lines up after N steps.
  assign res_next = (res_sh >> DIGIT) | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign ovf_next = (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.start) begin
            a_sh  <= bus.a;
            b_sh  <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.sub | bus.cin;
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1] ^ bus.sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= dsum[DIGIT];
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum   <= res_next;
            cout  <= dsum[DIGIT];
            ovf   <= ovf_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum;
  assign bus.cout = cout;
  assign bus.ovf  = ovf;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (W1/D1, W8/D1, W8/D4) checked against tables and an arithmetic model.
module tb_serial_adder;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  serial_adder_if #(.WIDTH(1)) if1 ();
  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(8)) if84 ();

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_w1  (.clk(clk), .rst(rst), .bus(if1));
  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8  (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w84 (.clk(clk), .rst(rst), .bus(if84));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  vec_t tbl[14];

  function automatic int nof(input int sel);
    return (sel == 0) ? 1 : (sel == 1) ? 8 : 2;
  endfunction

  function automatic int wof(input int sel);
    return (sel == 0) ? 1 : 8;
  endfunction

  // Reference: plain integer arithmetic over the operand width.
  task automatic model(input int w, input logic sb, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, output logic [7:0] s, output logic c, output logic o);
    longint m, ua, ub, sa, sbv, t, sr;
    m   = longint'(1) << w;
    ua  = longint'(a) % m;
    ub  = longint'(b) % m;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (sb) begin
      t  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sbv;
    end else begin
      t  = ua + ub + longint'(ci);
      c  = (t >= m);
      sr = sa + sbv + longint'(ci);
    end
    s = 8'((t + m) % m);
    o = (sr < -(m / 2)) || (sr >= m / 2);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input int sel, input logic st, input logic sb, input logic [7:0] a,
                    input logic [7:0] b, input logic ci);
    case (sel)
      0: begin if1.start = st; if1.sub = sb; if1.a = a[0]; if1.b = b[0]; if1.cin = ci; end
      1: begin if8.start = st; if8.sub = sb; if8.a = a; if8.b = b; if8.cin = ci; end
      default: begin if84.start = st; if84.sub = sb; if84.a = a; if84.b = b; if84.cin = ci; end
    endcase
  endtask

  task automatic rd(input int sel, output logic bz, output logic dn, output logic [7:0] s,
                    output logic c, output logic o);
    case (sel)
      0: begin bz = if1.busy; dn = if1.done; s = {7'b0, if1.sum}; c = if1.cout; o = if1.ovf; end
      1: begin bz = if8.busy; dn = if8.done; s = if8.sum; c = if8.cout; o = if8.ovf; end
      default: begin bz = if84.busy; dn = if84.done; s = if84.sum; c = if84.cout; o = if84.ovf; end
    endcase
  endtask

  // One transaction with timing checks; inject raises start mid-RUN with other operands.
  task automatic op(input int sel, input logic sb, input logic [7:0] a, input logic [7:0] b,
                    input logic ci, input bit inject, input string tag,
                    output logic [7:0] rs, output logic rc, output logic ro);
    int         n, nbusy, ndone, dpos;
    bit         held;
    logic       bz, dn, c, o;
    logic [7:0] s, s0;
    n = nof(sel); nbusy = 0; ndone = 0; dpos = -1; held = 1'b1;
    rs = '0; rc = 1'b0; ro = 1'b0;
    rd(sel, bz, dn, s0, c, o);
    wr(sel, 1'b1, sb, a, b, ci);
    @(posedge clk); #1;
    wr(sel, 1'b0, ~sb, 8'($urandom), 8'($urandom), ~ci);
    for (int j = 0; j <= n + 2; j++) begin
      rd(sel, bz, dn, s, c, o);
      if (bz) nbusy++;
      if (dn) begin ndone++; dpos = j; rs = s; rc = c; ro = o; end
      if (j < n && s !== s0) held = 1'b0;
      if (inject && j == 1) wr(sel, 1'b1, ~sb, ~a, ~b, ci);
      else if (inject && j == 2) wr(sel, 1'b0, sb, a, b, ci);
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(n));
    chk({tag, "_done_pulses"}, 32'(ndone), 32'd1);
    chk({tag, "_done_edge"}, 32'(dpos), 32'(n));
    chk({tag, "_sum_held"}, 32'(held), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rs, es, s;
    logic       rc, ro, ec, eo, bz, dn, c, o;
    int         sel, first, second, ndone;
    n_chk = 0;
    n_fail = 0;
    for (int i = 0; i < 8; i++)
      tbl[i] = '{0, 1'b0, 8'(i >> 2), 8'((i >> 1) & 1), 1'(i & 1),
                 8'((i >> 2) ^ ((i >> 1) & 1) ^ (i & 1)),
                 1'((i == 3) || (i >= 5)), 1'((i == 1) || (i == 6))};
    tbl[8]  = '{1, 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[9]  = '{1, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[10] = '{1, 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    tbl[11] = '{2, 1'b0, 8'h3C, 8'hC5, 1'b1, 8'h02, 1'b1, 1'b0};
    tbl[12] = '{1, 1'b1, 8'h10, 8'h10, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[13] = '{2, 1'b1, 8'h00, 8'h80, 1'b0, 8'h80, 1'b0, 1'b1};

    rst = 1'b1;
    for (int k = 0; k < 3; k++) wr(k, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd(k, bz, dn, s, c, o);
      chk($sformatf("reset_outputs_%0d", k), {20'b0, bz, dn, c, o, s}, 32'd0);
    end

    for (int i = 0; i < 14; i++) begin
      op(tbl[i].sel, tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0,
         $sformatf("vec%0d", i), rs, rc, ro);
      chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(tbl[i].s));
      chk($sformatf("vec%0d_cout", i), 32'(rc), 32'(tbl[i].c));
      chk($sformatf("vec%0d_ovf", i), 32'(ro), 32'(tbl[i].o));
    end

    // start raised during RUN must not disturb the running operation
    op(1, 1'b0, 8'h21, 8'h13, 1'b0, 1'b1, "inject", rs, rc, ro);
    chk("inject_sum", 32'(rs), 32'h34);
    chk("inject_cout_ovf", {30'b0, rc, ro}, 32'd0);

    // reset during the 4th RUN cycle aborts and clears
    op(1, 1'b0, 8'h40, 8'h02, 1'b0, 1'b0, "pre_rst", rs, rc, ro);
    chk("pre_rst_sum", 32'(rs), 32'h42);
    wr(1, 1'b1, 1'b0, 8'h12, 8'h34, 1'b0);
    @(posedge clk); #1;
    wr(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rd(1, bz, dn, s, c, o);
    chk("rst_busy_before", 32'(bz), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(1, bz, dn, s, c, o);
    chk("rst_busy_after", 32'(bz), 32'd0);
    chk("rst_sum_after", 32'(s), 32'd0);
    chk("rst_flags_after", {29'b0, dn, c, o}, 32'd0);
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      rd(1, bz, dn, s, c, o);
      if (dn) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    model(8, 1'b1, 8'h80, 8'h01, 1'b0, es, ec, eo);
    op(1, 1'b1, 8'h80, 8'h01, 1'b0, 1'b0, "post_rst", rs, rc, ro);
    chk("post_rst_result", {23'b0, rs, rc, ro}, {23'b0, es, ec, eo});

    // start held high: back-to-back launches every N+2 cycles
    wr(2, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0);
    first = -1; second = -1;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      rd(2, bz, dn, s, c, o);
      if (dn) begin
        if (first < 0) first = j;
        else if (second < 0) second = j;
      end
    end
    wr(2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("b2b_spacing", 32'(second - first), 32'd4);
    chk("b2b_sum", 32'(s), 32'h33);
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < 36; i++) begin
      logic       rsub, rcin;
      logic [7:0] ra, rb;
      sel  = i % 3;
      rsub = 1'($urandom);
      rcin = 1'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      model(wof(sel), rsub, ra, rb, rcin, es, ec, eo);
      op(sel, rsub, ra, rb, rcin, 1'b0, $sformatf("rnd%0d", i), rs, rc, ro);
      chk($sformatf("rnd%0d_result", i), {23'b0, rs, rc, ro}, {23'b0, es, ec, eo});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
